// File: rtl/uart_pkg.sv
// Shared types and constants for the UART echo tester: FSM states, bit-period
// calculation and the LFSR feedback polynomial.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_START,
    RECV,
    CHECK,
    DONE
  } state_t;

  // x^8 + x^6 + x^5 + x^4 + 1 as a tap mask over value[7:0] for a left-shifting Fibonacci LFSR
  localparam logic [7:0] LFSR_POLY = 8'hB8;

  function automatic int cycles_per_bit(input int clk_hz, input int bit_rate);
    return clk_hz / bit_rate;
  endfunction

endpackage

// File: rtl/uart_echo_tester_lfsr8.sv
// 8-bit Fibonacci LFSR producing the test byte sequence; load has priority
// over advance.
module lfsr8
  import uart_pkg::*;
#(
  parameter logic [7:0] INIT = 8'hA5
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       load,
  input  logic       advance,
  input  logic [7:0] seed,
  output logic [7:0] value
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      value <= INIT;
    end else if (load) begin
      value <= seed;
    end else if (advance) begin
      value <= {value[6:0], ^(value & LFSR_POLY)};
    end
  end

endmodule

// File: rtl/uart_echo_tester.sv
// UART echo tester: sends NUM_BYTES LFSR bytes, receives each echo and counts
// matches. Optional WAIT_START timeout when UART_ECHO_TESTER_TIMEOUT_EN is defined.
module uart_echo_tester
  import uart_pkg::*;
#(
  parameter int         CLK_HZ    = 50_000_000,
  parameter int         BIT_RATE  = 9600,
  parameter int         NUM_BYTES = 50,
  parameter logic [7:0] SEED      = 8'hA5
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  output logic        uart_txd,
  input  logic        uart_rxd,
  output logic        busy,
  output logic        done,
  output logic [15:0] pass_count,
  output logic [15:0] fail_count,
  output logic [7:0]  last_expected,
  output logic [7:0]  last_received
);

  localparam int          CPB       = cycles_per_bit(CLK_HZ, BIT_RATE);
  localparam logic [31:0] BIT_LAST  = 32'(CPB - 1);
  localparam logic [31:0] HALF_LAST = 32'(CPB / 2 - 1);
  localparam logic [15:0] IDX_LAST  = 16'(NUM_BYTES - 1);
`ifdef UART_ECHO_TESTER_TIMEOUT_EN
  localparam logic [31:0] TO_LAST   = 32'(20 * CPB - 1);
`endif

  state_t      state;
  logic [1:0]  rxd_sync;
  logic        rxd_s;
  logic [31:0] cyc_cnt;
  logic [3:0]  bit_idx;
  logic [15:0] byte_idx;
  logic        hunting;
  logic [7:0]  rx_shift;
  logic        rx_stop;
  logic [7:0]  lfsr_value;
  logic [9:0]  tx_frame;
  logic        lfsr_load;
  logic        lfsr_adv;
  logic        timeout_hit;
`ifdef UART_ECHO_TESTER_TIMEOUT_EN
  logic [31:0] to_cnt;
`endif

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign rxd_s     = rxd_sync[1];
  assign tx_frame  = {1'b1, lfsr_value, 1'b0};
  assign lfsr_load = start && ((state == IDLE) || (state == DONE));
  assign lfsr_adv  = (state == CHECK);
`ifdef UART_ECHO_TESTER_TIMEOUT_EN
  assign timeout_hit = (state == WAIT_START) && (to_cnt == TO_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  lfsr8 #(.INIT(SEED)) u_lfsr (
    .clk     (clk),
    .resetn  (resetn),
    .load    (lfsr_load),
    .advance (lfsr_adv),
    .seed    (SEED),
    .value   (lfsr_value)
  );

  // Synchronizer stage: rxd is asynchronous to clk
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rxd_sync <= 2'b11;
    else         rxd_sync <= {rxd_sync[0], uart_rxd};
  end

  // Receive datapath: shift register and stop bit, no reset needed
  always_ff @(posedge clk) begin
    if (timeout_hit) begin
      rx_shift <= 8'h00;
      rx_stop  <= 1'b0;
    end else if ((state == RECV) && (cyc_cnt == BIT_LAST)) begin
      if (bit_idx == 4'd8) rx_stop  <= rxd_s;
      else                 rx_shift <= {rxd_s, rx_shift[7:1]};
    end
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      uart_txd      <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass_count    <= 16'd0;
      fail_count    <= 16'd0;
      last_expected <= 8'h00;
      last_received <= 8'h00;
      cyc_cnt       <= 32'd0;
      bit_idx       <= 4'd0;
      byte_idx      <= 16'd0;
      hunting       <= 1'b0;
`ifdef UART_ECHO_TESTER_TIMEOUT_EN
      to_cnt        <= 32'd0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          uart_txd <= 1'b1;
          if (start) begin
            state      <= SEND;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass_count <= 16'd0;
            fail_count <= 16'd0;
            byte_idx   <= 16'd0;
            bit_idx    <= 4'd0;
            cyc_cnt    <= 32'd0;
          end
        end

        SEND: begin
          uart_txd <= tx_frame[bit_idx];
          if (cyc_cnt == BIT_LAST) begin
            cyc_cnt <= 32'd0;
            if (bit_idx == 4'd9) begin
              state   <= WAIT_START;
              hunting <= 1'b0;
`ifdef UART_ECHO_TESTER_TIMEOUT_EN
              to_cnt  <= 32'd0;
`endif
            end else begin
              bit_idx <= bit_idx + 4'd1;
            end
          end else begin
            cyc_cnt <= cyc_cnt + 32'd1;
          end
        end

        WAIT_START: begin
          uart_txd <= 1'b1;
`ifdef UART_ECHO_TESTER_TIMEOUT_EN
          to_cnt <= to_cnt + 32'd1;
`endif
          if (timeout_hit) begin
            state <= CHECK;
          end else if (!hunting) begin
            if (!rxd_s) begin
              hunting <= 1'b1;
              cyc_cnt <= 32'd0;
            end
          end else if (cyc_cnt == HALF_LAST) begin
            // Re-check at mid start bit; a high line here was a glitch
            hunting <= 1'b0;
            cyc_cnt <= 32'd0;
            if (!rxd_s) begin
              state   <= RECV;
              bit_idx <= 4'd0;
            end
          end else begin
            cyc_cnt <= cyc_cnt + 32'd1;
          end
        end

        RECV: begin
          uart_txd <= 1'b1;
          if (cyc_cnt == BIT_LAST) begin
            cyc_cnt <= 32'd0;
            if (bit_idx == 4'd8) state   <= CHECK;
            else                 bit_idx <= bit_idx + 4'd1;
          end else begin
            cyc_cnt <= cyc_cnt + 32'd1;
          end
        end

        CHECK: begin
          uart_txd      <= 1'b1;
          last_expected <= lfsr_value;
          last_received <= rx_shift;
          if ((rx_shift == lfsr_value) && rx_stop) pass_count <= sat_inc(pass_count);
          else                                     fail_count <= sat_inc(fail_count);
          if (byte_idx == IDX_LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            byte_idx <= byte_idx + 16'd1;
            state    <= SEND;
            bit_idx  <= 4'd0;
            cyc_cnt  <= 32'd0;
          end
        end

        default: begin
          state    <= IDLE;
          uart_txd <= 1'b1;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_echo_tester.sv
// Directed bench for uart_echo_tester: delayed-echo line model with optional
// bit-3 inversion or a forced-low stop bit, plus reset and stuck-line runs.
module tb_uart_echo_tester;

  localparam int CLK_HZ   = 100;
  localparam int BIT_RATE = 10;
  localparam int CPB      = CLK_HZ / BIT_RATE;
  localparam int NBYTES   = 50;
  localparam int DLY      = 110;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic        uart_txd;
  logic        uart_rxd;
  logic        busy;
  logic        done;
  logic [15:0] pass_count;
  logic [15:0] fail_count;
  logic [7:0]  last_expected;
  logic [7:0]  last_received;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // echo line model state
  logic           tb_clr;
  logic           tie1;
  int             mode;
  logic           tx_act;
  int             tx_cnt;
  int             tx_frame;
  int             pos;
  int             bitn;
  logic           mod_txd;
  logic [DLY-1:0] dl;

  always #5 clk = ~clk;

  uart_echo_tester #(
    .CLK_HZ    (CLK_HZ),
    .BIT_RATE  (BIT_RATE),
    .NUM_BYTES (NBYTES),
    .SEED      (8'hA5)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .start         (start),
    .uart_txd      (uart_txd),
    .uart_rxd      (uart_rxd),
    .busy          (busy),
    .done          (done),
    .pass_count    (pass_count),
    .fail_count    (fail_count),
    .last_expected (last_expected),
    .last_received (last_received)
  );

  always_comb begin
    pos     = tx_act ? tx_cnt : 0;
    bitn    = pos / CPB;
    mod_txd = uart_txd;
    if ((tx_act || !uart_txd) && mode == 1 && bitn == 4) mod_txd = ~uart_txd;
    if ((tx_act || !uart_txd) && mode == 2 && tx_frame == 2 && bitn == 9) mod_txd = 1'b0;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tb_clr) begin
      tx_act   <= 1'b0;
      tx_cnt   <= 0;
      tx_frame <= 0;
      dl       <= '1;
    end else begin
      dl <= {dl[DLY-2:0], mod_txd};
      if (!tx_act) begin
        if (!uart_txd) begin
          tx_act <= 1'b1;
          tx_cnt <= 1;
        end
      end else if (tx_cnt == 10 * CPB - 1) begin
        tx_act   <= 1'b0;
        tx_frame <= tx_frame + 1;
      end else begin
        tx_cnt <= tx_cnt + 1;
      end
    end
  end

  assign uart_rxd = tie1 ? 1'b1 : dl[DLY-1];

  function automatic logic [7:0] lfsr_model(input int n);
    logic [7:0] v;
    v = 8'hA5;
    for (int i = 0; i < n; i++) v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    tb_clr = 1'b1;
    @(negedge clk);
    tb_clr = 1'b0;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic extra_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(done), 32'd1);
  endtask

  initial begin
    int         n;
    int         t0;
    int         t_run1;
    logic [7:0] b;
    logic [7:0] exp_last;

    exp_last = lfsr_model(NBYTES - 1);
    resetn = 1'b0;
    start  = 1'b0;
    tb_clr = 1'b1;
    tie1   = 1'b0;
    mode   = 0;
    repeat (3) @(negedge clk);

    check("rst_txd", 32'(uart_txd), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass_count), 32'd0);
    check("rst_fail", 32'(fail_count), 32'd0);
    check("rst_last_exp", 32'(last_expected), 32'd0);
    check("rst_last_rcv", 32'(last_received), 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    // Run 1: clean echo, first frame shape and contents
    pulse_start();
    t0 = cyc;
    check("txd_high_on_send_entry", 32'(uart_txd), 32'd1);
    check("busy_in_send", 32'(busy), 32'd1);
    @(negedge clk);
    check("txd_start_low", 32'(uart_txd), 32'd0);
    n = 0;
    while (uart_txd === 1'b0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("start_bit_len", 32'(n), 32'(CPB));
    repeat (CPB / 2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      b[i] = uart_txd;
      repeat (CPB) @(negedge clk);
    end
    check("first_byte", 32'(b), 32'h0000_00A5);
    wait_done("loop_done", 20000);
    t_run1 = cyc - t0;
    check("loop_pass", 32'(pass_count), 32'(NBYTES));
    check("loop_fail", 32'(fail_count), 32'd0);
    check("loop_last_exp", 32'(last_expected), 32'(exp_last));
    check("loop_last_rcv", 32'(last_received), 32'(exp_last));
    check("loop_busy_low", 32'(busy), 32'd0);

    // Run 2: start pulses while busy must not change timing
    pulse_start();
    t0 = cyc;
    repeat (50) @(negedge clk);
    extra_start();
    repeat (2000) @(negedge clk);
    extra_start();
    wait_done("restart_done", 20000);
    check("restart_run_len", 32'(cyc - t0), 32'(t_run1));
    check("restart_pass", 32'(pass_count), 32'(NBYTES));

    // Run 3: data bit 3 inverted on every echo
    mode = 1;
    pulse_start();
    wait_done("inv_done", 20000);
    check("inv_pass", 32'(pass_count), 32'd0);
    check("inv_fail", 32'(fail_count), 32'(NBYTES));
    check("inv_last_exp", 32'(last_expected), 32'(exp_last));
    check("inv_last_rcv", 32'(last_received), 32'(exp_last ^ 8'h08));

    // Run 4: stop bit forced low on byte 2 only
    mode = 2;
    pulse_start();
    wait_done("stop_done", 20000);
    check("stop_pass", 32'(pass_count), 32'(NBYTES - 1));
    check("stop_fail", 32'(fail_count), 32'd1);

    // Asynchronous reset in the middle of data bit 4 of frame 1
    mode = 0;
    pulse_start();
    n = 0;
    while (pass_count !== 16'd1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("pre_reset_pass", 32'(pass_count), 32'd1);
    n = 0;
    while (uart_txd !== 1'b0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    repeat (5 * CPB + CPB / 2) @(negedge clk);
    check("pre_reset_busy", 32'(busy), 32'd1);
    #2 resetn = 1'b0;
    #1;
    check("mid_reset_txd", 32'(uart_txd), 32'd1);
    check("mid_reset_busy", 32'(busy), 32'd0);
    check("mid_reset_pass", 32'(pass_count), 32'd0);
    check("mid_reset_fail", 32'(fail_count), 32'd0);
    check("mid_reset_done", 32'(done), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // Echo line stuck high
    tie1 = 1'b1;
    pulse_start();
`ifdef UART_ECHO_TESTER_TIMEOUT_EN
    wait_done("tie_done", 30000);
    check("tie_fail", 32'(fail_count), 32'(NBYTES));
    check("tie_pass", 32'(pass_count), 32'd0);
    check("tie_last_rcv", 32'(last_received), 32'd0);
    check("tie_last_exp", 32'(last_expected), 32'(exp_last));
`else
    repeat (3000) @(negedge clk);
    check("tie_busy", 32'(busy), 32'd1);
    check("tie_done", 32'(done), 32'd0);
    check("tie_fail", 32'(fail_count), 32'd0);
    check("tie_pass", 32'(pass_count), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
